// File: rtl/cordic_defs.sv
// Shared definitions for the CORDIC iteration sequencer.
//   state_t   : sequencer FSM encoding (IDLE / RUN / DONE); 2'd3 is unused
//               and the FSM steers it back to IDLE on the next clock.
//   W_DEFAULT : default width of count, index and remaining-count signals.
package cordic_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int W_DEFAULT = 4;

endpackage

// File: rtl/counter_down.sv
// Loadable W-bit down-counter with synchronous active-high reset.
// Ports:
//   clk        in   clock, all updates on posedge
//   rst        in   synchronous reset, clears the count to zero
//   load       in   load d into the count (has priority over enable)
//   enable     in   decrement by one; saturates at zero instead of wrapping
//   d          in   value to load
//   q          out  current count
//   zero_tick  out  q == 0
module counter_down
  import cordic_defs::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero_tick
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (enable && (r_q != '0)) begin
      // Guarded so a stray enable at zero can never wrap to all-ones.
      r_q <= r_q - ONE;
    end
  end

  assign q         = r_q;
  assign zero_tick = (r_q == '0);

endmodule

// File: rtl/iter_countdown_ctrl.sv
// Down-counting iteration sequencer for the CORDIC datapath.
// A start in IDLE latches the iteration count N; the block then issues exactly
// N iteration-enable pulses with ascending index 0..N-1, stalling while hold
// is high, and finally raises done until it is acknowledged.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   start     in   request a new sequence (only looked at in IDLE)
//   d         in   iteration count N, latched when start is accepted
//   hold      in   stall; freezes the sequence while in RUN
//   ack       in   acknowledge done (only looked at in DONE)
//   busy      out  high in RUN and DONE
//   iter_en   out  one iteration this cycle (RUN and not hold)
//   idx       out  ascending iteration index (n - q)
//   last      out  final iteration of the sequence this cycle
//   done      out  high in DONE until ack
//   q         out  remaining iterations
//   min_tick  out  q == 0
//   max_tick  out  q == all-ones
module iter_countdown_ctrl
  import cordic_defs::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] d,
  input  logic         hold,
  input  logic         ack,
  output logic         busy,
  output logic         iter_en,
  output logic [W-1:0] idx,
  output logic         last,
  output logic         done,
  output logic [W-1:0] q,
  output logic         min_tick,
  output logic         max_tick
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_n;
  logic [W-1:0] w_q;
  logic         w_zero;
  logic         w_load;
  logic         w_iter_en;

  counter_down #(.W(W)) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .enable    (w_iter_en),
    .d         (d),
    .q         (w_q),
    .zero_tick (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_n <= d;
      end
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    w_load       = 1'b0;
    w_iter_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_IDLE;
        if (start) begin
          w_load = 1'b1;
          // A zero-length request skips RUN entirely.
          w_state_next = (d == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
        w_iter_en    = ~hold;
        if (!hold && (w_q == ONE)) begin
          w_state_next = ST_DONE;
        end else if (w_zero) begin
          // Defensive exit: RUN with nothing left to do cannot stall forever.
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ack ? ST_IDLE : ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign busy     = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done     = (r_state == ST_DONE);
  assign iter_en  = w_iter_en;
  assign idx      = r_n - w_q;
  assign last     = w_iter_en && (w_q == ONE);
  assign q        = w_q;
  assign min_tick = w_zero;
  assign max_tick = (w_q == {W{1'b1}});

endmodule

// File: tb/tb_iter_countdown_ctrl.sv
module tb_iter_countdown_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] d;
  logic         hold;
  logic         ack;
  logic         busy;
  logic         iter_en;
  logic [W-1:0] idx;
  logic         last;
  logic         done;
  logic [W-1:0] q;
  logic         min_tick;
  logic         max_tick;

  iter_countdown_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .d        (d),
    .hold     (hold),
    .ack      (ack),
    .busy     (busy),
    .iter_en  (iter_en),
    .idx      (idx),
    .last     (last),
    .done     (done),
    .q        (q),
    .min_tick (min_tick),
    .max_tick (max_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0=idle 1=run 2=done, requested length, iterations issued.
  int m_phase  = 0;
  int m_n      = 0;
  int m_issued = 0;
  int pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic i_rst, input logic i_start, input logic [W-1:0] i_d,
                      input logic i_hold, input logic i_ack);
    int e_q;
    bit e_iter;
    @(negedge clk);
    rst = i_rst; start = i_start; d = i_d; hold = i_hold; ack = i_ack;
    #1;
    e_q    = m_n - m_issued;
    e_iter = (m_phase == 1) && !i_hold;
    chk("busy",     busy,     (m_phase != 0));
    chk("done",     done,     (m_phase == 2));
    chk("iter_en",  iter_en,  e_iter);
    chk("idx",      idx,      m_issued);
    chk("q",        q,        e_q);
    chk("last",     last,     e_iter && (e_q == 1));
    chk("min_tick", min_tick, (e_q == 0));
    chk("max_tick", max_tick, (e_q == (2**W - 1)));
    if (iter_en === 1'b1) pulse_cnt++;
    @(posedge clk);
    if (i_rst) begin
      m_phase = 0; m_n = 0; m_issued = 0;
    end else begin
      case (m_phase)
        0: if (i_start) begin
          $display("txn: start accepted n=%0d", i_d);
          m_n = i_d; m_issued = 0;
          m_phase = (i_d == 0) ? 2 : 1;
        end
        1: if (!i_hold) begin
          m_issued++;
          if (m_issued == m_n) m_phase = 2;
        end
        default: if (i_ack) m_phase = 0;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; d = '0; hold = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then reset held two cycles in the middle of a d=5 run.
    step(0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);

    // d=4, no hold; done appears after the fourth pulse.
    step(0, 1, 4, 0, 0);
    repeat (4) step(0, 0, 9, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // d=3 with hold in cycles 2-3; done in cycle 6.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // d=0 goes straight to done with no pulse; ack returns to idle.
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Full-scale d=15: max_tick in the first run cycle, exactly 15 pulses.
    pulse_cnt = 0;
    step(0, 1, 15, 0, 0);
    repeat (15) step(0, 0, 0, 0, 0);
    chk("full_scale_pulses", pulse_cnt, 15);
    step(0, 0, 0, 0, 1);

    // start together with ack in done is ignored; next start runs 2 iterations.
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 1);
    pulse_cnt = 0;
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("restart_pulses", pulse_cnt, 2);
    step(0, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
